tm_clause_inference: RTL

Inference-side reader of the Tsetlin-machine TA state bank that the feedback block writes.
- Per transaction it latches literals, per-clause TA states and clause weights.
- It derives each TA's include/exclude action and evaluates one clause per cycle.
- It accumulates the signed weighted vote and returns actions, conjunction_result, class sum and prediction to the training controller through a valid/ready handshake.
- Its actions/conjunction_result outputs are the inputs the feedback block consumes.

---
 rtl/tm_pkg.sv | 31 +++
 rtl/tm_clause_eval.sv | 29 ++
 rtl/tm_clause_inference.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tm_pkg.sv
// ============================================================================
// tm_pkg : shared Tsetlin-machine types and helpers (FSM states, clog2, TA test)
// Rev 1.0
// ============================================================================
`default_nettype none

package tm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } tm_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // A TA votes "include" once its state reaches the upper half of its range.
    function automatic logic ta_include(input logic [31:0] state, input int width);
        return state >= (32'd1 << (width - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/tm_clause_eval.sv
// ============================================================================
// tm_clause_eval : combinational evaluation of one clause (actions + conjunction)
// Rev 1.0
// ============================================================================
`default_nettype none

module tm_clause_eval
    import tm_pkg::*;
#(
    parameter int LITERAL_NUM = 8,
    parameter int STATE_WIDTH = 4
) (
    input  logic [LITERAL_NUM*STATE_WIDTH-1:0] clause_state,
    input  logic [LITERAL_NUM-1:0]             literals,
    input  logic                               train,
    output logic [LITERAL_NUM-1:0]             action,
    output logic                               conj
);

    for (genvar l = 0; l < LITERAL_NUM; l++) begin : g_lit
        assign action[l] = ta_include(32'(clause_state[l*STATE_WIDTH +: STATE_WIDTH]), STATE_WIDTH);
    end

    // An empty clause fires only while training so it can still receive feedback.
    assign conj = (|action) ? (&(literals | ~action)) : train;

endmodule

`default_nettype wire

// File: rtl/tm_clause_inference.sv
// ============================================================================
// tm_clause_inference : serial clause evaluation with saturating weighted vote
// Rev 1.0
// ============================================================================
`default_nettype none

module tm_clause_inference
    import tm_pkg::*;
#(
    parameter int CLAUSE_NUM   = 4,
    parameter int LITERAL_NUM  = 8,
    parameter int STATE_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = WEIGHT_WIDTH + clog2(CLAUSE_NUM)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      train,
    input  logic [LITERAL_NUM-1:0]                    literals,
    input  logic [CLAUSE_NUM*LITERAL_NUM*STATE_WIDTH-1:0] state_in,
    input  logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]        weight_in,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [CLAUSE_NUM*LITERAL_NUM-1:0]         actions,
    output logic [CLAUSE_NUM-1:0]                     conjunction_result,
    output logic [SUM_WIDTH-1:0]                      class_sum,
    output logic                                      prediction
);

    localparam int IDX_W       = (CLAUSE_NUM > 1) ? clog2(CLAUSE_NUM) : 1;
    localparam int CLAUSE_BITS = LITERAL_NUM * STATE_WIDTH;
    localparam int EXT_W       = SUM_WIDTH + 1 - WEIGHT_WIDTH;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(CLAUSE_NUM - 1);
    localparam logic [SUM_WIDTH-1:0] SUM_MAX  = {1'b0, {(SUM_WIDTH-1){1'b1}}};
    localparam logic [SUM_WIDTH-1:0] SUM_MIN  = {1'b1, {(SUM_WIDTH-1){1'b0}}};

    tm_state_t                               r_fsm;
    logic [LITERAL_NUM-1:0]                  r_literals;
    logic [CLAUSE_NUM*CLAUSE_BITS-1:0]       r_state;
    logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]      r_weight;
    logic                                    r_train;
    logic [IDX_W-1:0]                        r_idx;
    logic [SUM_WIDTH-1:0]                    r_acc;

    logic [CLAUSE_BITS-1:0]                  w_clause_state;
    logic [WEIGHT_WIDTH-1:0]                 w_weight;
    logic [LITERAL_NUM-1:0]                  w_action;
    logic                                    w_conj;
    logic [SUM_WIDTH:0]                      w_sum;
    logic [SUM_WIDTH-1:0]                    w_sat;

    assign in_ready       = (r_fsm == ST_IDLE) & ~rst;
    assign w_clause_state = r_state[32'(r_idx)*CLAUSE_BITS +: CLAUSE_BITS];
    assign w_weight       = r_weight[32'(r_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    tm_clause_eval #(
        .LITERAL_NUM (LITERAL_NUM),
        .STATE_WIDTH (STATE_WIDTH)
    ) u_eval (
        .clause_state (w_clause_state),
        .literals     (r_literals),
        .train        (r_train),
        .action       (w_action),
        .conj         (w_conj)
    );

    // One guard bit lets overflow show up as a sign disagreement in the top two bits.
    assign w_sum = {r_acc[SUM_WIDTH-1], r_acc} + {{EXT_W{w_weight[WEIGHT_WIDTH-1]}}, w_weight};
    assign w_sat = (w_sum[SUM_WIDTH] != w_sum[SUM_WIDTH-1])
                 ? (w_sum[SUM_WIDTH] ? SUM_MIN : SUM_MAX)
                 : w_sum[SUM_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm              <= ST_IDLE;
            r_literals         <= '0;
            r_state            <= '0;
            r_weight           <= '0;
            r_train            <= 1'b0;
            r_idx              <= '0;
            r_acc              <= '0;
            actions            <= '0;
            conjunction_result <= '0;
            class_sum          <= '0;
            prediction         <= 1'b0;
            out_valid          <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_literals <= literals;
                        r_state    <= state_in;
                        r_weight   <= weight_in;
                        r_train    <= train;
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_fsm      <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    actions[32'(r_idx)*LITERAL_NUM +: LITERAL_NUM] <= w_action;
                    conjunction_result[r_idx]                      <= w_conj;
                    if (w_conj) r_acc <= w_sat;
                    if (r_idx == LAST_IDX) r_fsm <= ST_DONE;
                    else                   r_idx <= r_idx + 1'b1;
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        class_sum  <= r_acc;
                        prediction <= ~r_acc[SUM_WIDTH-1];
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        r_fsm     <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
